// File: rtl/dlx_pkg.sv
// Shared DLX front-end types and instruction field positions.
// Bits are numbered big-endian: bit 0 is the MSB of a 32-bit word.
package dlx_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_ISSUE = 2'd2,
        S_HALT  = 2'd3
    } fetch_state_t;

    localparam int IMM16_LSB      = 16;
    localparam int OFF26_LSB      = 6;
    localparam int FAULT_TIMEOUT  = 0;
    localparam int FAULT_MISALIGN = 1;

    function automatic logic [0:31] sext16(input logic [0:15] v);
        return {{16{v[0]}}, v};
    endfunction

    function automatic logic [0:31] sext26(input logic [0:25] v);
        return {{6{v[0]}}, v};
    endfunction

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for a retiring instruction: redirect priority mux,
// offset adders and word-alignment check.
module fetch_next_pc
    import dlx_pkg::*;
(
    input  logic [0:31] pc,
    input  logic [0:31] instr,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [0:31] reg_target,
    output logic [0:31] next_pc,
    output logic        misaligned
);

    logic [0:31] seq_pc_s;
    logic [0:31] target_s;
    logic [0:5]  unused_opcode_s;

    assign unused_opcode_s = instr[0:5];

    // Priority: register jump, then PC-relative jump, then taken branch, else fall through.
    always_comb begin
        seq_pc_s = pc + 32'd4;
        if (jump_reg) begin
            target_s = reg_target;
        end else if (jump) begin
            target_s = seq_pc_s + sext26(instr[OFF26_LSB:31]);
        end else if (branch && branch_taken) begin
            target_s = seq_pc_s + sext16(instr[IMM16_LSB:31]);
        end else begin
            target_s = seq_pc_s;
        end
        misaligned = (target_s[30:31] != 2'b00);
        next_pc    = {target_s[0:29], 2'b00};
    end

endmodule

// File: rtl/instr_fetch_unit.sv
// DLX instruction fetch: PC ownership, req/ack fetch from instruction memory,
// instruction hand-off to decode, and sticky timeout/misalignment faults.
module instr_fetch_unit
    import dlx_pkg::*;
#(
    parameter logic [0:31] RESET_PC = 32'h0000_0000,
    parameter int          MAX_WAIT = 16
)(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [0:31] imem_addr,
    input  logic        imem_ack,
    input  logic [0:31] imem_data,
    output logic [0:31] instr,
    output logic        instr_valid,
    output logic [0:31] pc,
    output logic [0:31] link_addr,
    input  logic        retire,
    input  logic        branch,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jump_reg,
    input  logic [0:31] reg_target,
    output logic [0:1]  fault
);

    localparam int WAIT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    fetch_state_t      state_q, state_d;
    logic [0:31]       pc_q, pc_d;
    logic [0:31]       instr_q, instr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              imem_req_q, imem_req_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [0:1]        fault_q, fault_d;

    logic [0:31]       next_pc_s;
    logic              misaligned_s;

    fetch_next_pc u_next_pc (
        .pc           (pc_q),
        .instr        (instr_q),
        .branch       (branch),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jump_reg     (jump_reg),
        .reg_target   (reg_target),
        .next_pc      (next_pc_s),
        .misaligned   (misaligned_s)
    );

    // Fetch FSM next-state, PC/instruction capture, wait counter and fault flags.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        wait_cnt_d = wait_cnt_q;
        fault_d    = fault_q;
        case (state_q)
            S_IDLE: begin
                state_d    = S_FETCH;
                wait_cnt_d = {WAIT_W{1'b0}};
            end
            S_FETCH: begin
                // An ack on the last allowed cycle still counts as a hit.
                if (imem_ack) begin
                    instr_d = imem_data;
                    state_d = S_ISSUE;
                end else if (wait_cnt_q == WAIT_W'(MAX_WAIT - 1)) begin
                    fault_d[FAULT_TIMEOUT] = 1'b1;
                    state_d                = S_HALT;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_ISSUE: begin
                if (retire) begin
                    pc_d       = next_pc_s;
                    wait_cnt_d = {WAIT_W{1'b0}};
                    state_d    = S_FETCH;
                    if (misaligned_s) begin
                        fault_d[FAULT_MISALIGN] = 1'b1;
                    end else begin
                        fault_d[FAULT_MISALIGN] = fault_q[FAULT_MISALIGN];
                    end
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_HALT;
            end
        endcase
        imem_req_d    = (state_d == S_FETCH);
        instr_valid_d = (state_d == S_ISSUE);
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b0;
            wait_cnt_q    <= {WAIT_W{1'b0}};
            fault_q       <= 2'b00;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            instr_q       <= instr_d;
            instr_valid_q <= instr_valid_d;
            imem_req_q    <= imem_req_d;
            wait_cnt_q    <= wait_cnt_d;
            fault_q       <= fault_d;
        end
    end

    assign imem_req    = imem_req_q;
    assign imem_addr   = {pc_q[0:29], 2'b00};
    assign instr       = instr_q;
    assign instr_valid = instr_valid_q;
    assign pc          = pc_q;
    assign link_addr   = pc_q + 32'd4;
    assign fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations plus randomized fetch/retire traffic against a behavioural model.
module tb_instr_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam int          MW  = 8;

    localparam int P_IDLE  = 0;
    localparam int P_FETCH = 1;
    localparam int P_HOLD  = 2;
    localparam int P_HALT  = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        retire, branch, branch_taken, jump, jump_reg;
    logic [31:0] reg_target;
    logic [1:0]  fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.RESET_PC(RPC), .MAX_WAIT(MW)) dut (
        .clk          (clk),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_data    (imem_data),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .pc           (pc),
        .link_addr    (link_addr),
        .retire       (retire),
        .branch       (branch),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jump_reg     (jump_reg),
        .reg_target   (reg_target),
        .fault        (fault)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int          m_phase = P_IDLE;
    int          m_wait  = 0;
    logic [31:0] m_pc    = RPC;
    logic [31:0] m_instr = 32'h0;
    logic        m_ftime = 1'b0;
    logic        m_fmis  = 1'b0;

    function automatic logic [31:0] redirect_target(input logic [31:0] cur_pc, input logic [31:0] iw,
                                                    input logic jr, input logic j, input logic br,
                                                    input logic tk, input logic [31:0] rt);
        logic [31:0] fall;
        fall = cur_pc + 32'd4;
        if (jr)           return rt;
        if (j)            return fall + 32'($signed(iw[25:0]));
        if (br && tk)     return fall + 32'($signed(iw[15:0]));
        return fall;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_phase <= P_IDLE;
            m_wait  <= 0;
            m_pc    <= RPC;
            m_instr <= 32'h0;
            m_ftime <= 1'b0;
            m_fmis  <= 1'b0;
        end else if (m_phase == P_IDLE) begin
            m_phase <= P_FETCH;
            m_wait  <= 0;
        end else if (m_phase == P_FETCH) begin
            if (imem_ack) begin
                m_instr <= imem_data;
                m_phase <= P_HOLD;
            end else if (m_wait + 1 == MW) begin
                m_ftime <= 1'b1;
                m_phase <= P_HALT;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else if (m_phase == P_HOLD && retire) begin
            logic [31:0] t;
            t = redirect_target(m_pc, m_instr, jump_reg, jump, branch, branch_taken, reg_target);
            m_pc    <= {t[31:2], 2'b00};
            if (t[1:0] != 2'b00) m_fmis <= 1'b1;
            m_phase <= P_FETCH;
            m_wait  <= 0;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        check("req",   {31'b0, imem_req},    {31'b0, m_phase == P_FETCH});
        check("valid", {31'b0, instr_valid}, {31'b0, m_phase == P_HOLD});
        check("addr",  imem_addr, m_pc);
        check("pc",    pc,        m_pc);
        check("link",  link_addr, m_pc + 32'd4);
        check("instr", instr,     m_instr);
        check("fault", {30'b0, fault}, {30'b0, m_ftime, m_fmis});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        imem_ack = 1'b0; imem_data = 32'h0; retire = 1'b0; branch = 1'b0;
        branch_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0; reg_target = 32'h0;
    endtask

    task automatic apply_reset;
        clear_inputs();
        reset = 1'b1;
        step(); step();
        reset = 1'b0;
    endtask

    task automatic wait_req;
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin step(); n++; end
        if (imem_req !== 1'b1) check("wait_req", {31'b0, imem_req}, 32'd1);
    endtask

    // Ack arrives lat cycles after the request went high (lat >= 1).
    task automatic do_fetch(input int lat, input logic [31:0] data);
        wait_req();
        for (int k = 1; k < lat; k++) begin
            retire = 1'($urandom_range(0, 1));
            step();
        end
        retire    = 1'b0;
        imem_ack  = 1'b1;
        imem_data = data;
        step();
        imem_ack  = 1'b0;
        imem_data = $urandom;
    endtask

    task automatic retire_op(input logic jr, input logic j, input logic br, input logic tk,
                             input logic [31:0] rt, input int extra);
        int n = 0;
        while (instr_valid !== 1'b1 && n < 20) begin step(); n++; end
        if (instr_valid !== 1'b1) check("wait_valid", {31'b0, instr_valid}, 32'd1);
        for (int k = 0; k < extra; k++) begin
            imem_ack  = 1'($urandom_range(0, 1));
            imem_data = $urandom;
            step();
        end
        imem_ack = 1'b0;
        jump_reg = jr; jump = j; branch = br; branch_taken = tk; reg_target = rt;
        retire   = 1'b1;
        step();
        clear_inputs();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        clear_inputs();
        reset = 1'b1;
        step(); step();
        check("rst_req",   {31'b0, imem_req},    32'd0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_addr",  imem_addr, 32'h0000_0100);
        check("rst_link",  link_addr, 32'h0000_0104);
        check("rst_instr", instr,     32'h0);
        check("rst_fault", {30'b0, fault}, 32'd0);
        reset = 1'b0;

        // basic fetch with 3-cycle memory latency
        do_fetch(3, 32'h2001_0005);
        check("t1_instr", instr, 32'h2001_0005);
        check("t1_valid", {31'b0, instr_valid}, 32'd1);
        check("t1_addr",  imem_addr, 32'h0000_0100);
        check("t1_link",  link_addr, 32'h0000_0104);
        retire_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        check("t1_next",  imem_addr, 32'h0000_0104);
        check("t1_req",   {31'b0, imem_req}, 32'd1);

        // branch taken / not taken from 0x200
        do_fetch(1, 32'h0);
        retire_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 1);
        do_fetch(2, 32'h1000_FFF8);
        retire_op(1'b0, 1'b0, 1'b1, 1'b1, 32'h0, 0);
        check("t2_taken", imem_addr, 32'h0000_01FC);
        do_fetch(1, 32'h0);
        retire_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 0);
        do_fetch(1, 32'h1000_FFF8);
        retire_op(1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 2);
        check("t2_not_taken", imem_addr, 32'h0000_0204);

        // jump and jump-register priority
        do_fetch(1, 32'h0);
        retire_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_1000, 0);
        do_fetch(1, 32'h0800_0010);
        retire_op(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0);
        check("t3_jump", imem_addr, 32'h0000_1014);
        do_fetch(1, 32'h0800_0010);
        retire_op(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_3000, 0);
        check("t3_jr_prio", imem_addr, 32'h0000_3000);
        check("t3_fault",   {30'b0, fault}, 32'd0);

        // misaligned target, wrap-around, ack on the last allowed cycle
        do_fetch(1, 32'h0);
        retire_op(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_3002, 0);
        check("t5_mis_addr",  imem_addr, 32'h0000_3000);
        check("t5_mis_fault", {30'b0, fault}, 32'd1);
        do_fetch(2, 32'h0);
        retire_op(1'b1, 1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 0);
        check("t5_top_addr", imem_addr, 32'hFFFF_FFFC);
        check("t5_top_link", link_addr, 32'h0000_0000);
        do_fetch(MW, 32'h0);
        check("t5_lastack_valid", {31'b0, instr_valid}, 32'd1);
        check("t5_lastack_fault", {30'b0, fault}, 32'd1);
        retire_op(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 0);
        check("t5_wrap", imem_addr, 32'h0000_0000);
        check("t5_wrap_fault", {30'b0, fault}, 32'd1);

        // fetch timeout
        apply_reset();
        wait_req();
        repeat (MW) step();
        check("t4_req",   {31'b0, imem_req}, 32'd0);
        check("t4_fault", {30'b0, fault},    32'd2);
        imem_ack = 1'b1; retire = 1'b1;
        repeat (4) step();
        check("t4_halt_req",   {31'b0, imem_req},    32'd0);
        check("t4_halt_valid", {31'b0, instr_valid}, 32'd0);
        check("t4_halt_fault", {30'b0, fault},       32'd2);
        clear_inputs();

        // reset in the same cycle as an ack
        apply_reset();
        wait_req();
        step();
        imem_ack  = 1'b1;
        imem_data = 32'hDEAD_BEEF;
        reset     = 1'b1;
        #1;
        check("t6_req",   {31'b0, imem_req},    32'd0);
        check("t6_valid", {31'b0, instr_valid}, 32'd0);
        step();
        imem_ack = 1'b0;
        reset    = 1'b0;
        wait_req();
        check("t6_addr",  imem_addr, 32'h0000_0100);
        check("t6_instr", instr,     32'h0);

        // randomized traffic checked by the model
        apply_reset();
        for (int i = 0; i < 200; i++) begin
            logic [31:0] rt;
            rt = $urandom;
            if ($urandom_range(0, 3) != 0) rt[1:0] = 2'b00;
            do_fetch($urandom_range(1, MW), $urandom);
            retire_op(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 3) == 0),
                      1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), rt,
                      $urandom_range(0, 2));
            if (i % 40 == 39) apply_reset();
        end
        step(); step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
